// File: rtl/ag32gbd_frame_sched_pkg.sv
// ag32gbd_frame_sched_pkg: shared FSM states, default sizes and buffer-base helper for the frame scheduler and BRAM ctrl.
package ag32gbd_frame_sched_pkg;
  typedef enum logic [1:0] {S_IDLE, S_WAIT_DONE, S_GAP, S_FULL} state_e;
  localparam int BLOCK_BYTES_DEF = 256;
  localparam int OFFSET_W_DEF = 8;
  function automatic logic [OFFSET_W_DEF:0] buf_base(input logic sel);
    return sel ? (OFFSET_W_DEF+1)'(BLOCK_BYTES_DEF) : '0;
  endfunction
endpackage

// File: rtl/ag32gbd_frame_sched_if.sv
// ag32gbd_frame_sched_if: pixel stream, BRAM write and reader handshake bundle; master = scheduler, slave = environment.
interface ag32gbd_frame_sched_if #(parameter int OFFSET_W = 8);
  logic [7:0] PixData;
  logic PixValid;
  logic PixReady;
  logic FrameStart;
  logic RequestWriteBuffer;
  logic [7:0] BufferWriteData;
  logic [OFFSET_W-1:0] BufferWriteOffset;
  logic BufferWriteDataDone;
  logic FlipBuffer;
  logic BlockReady;
  logic BlockConsumed;
  logic [7:0] BlockCount;
  logic SchedError;
  modport master (
    input PixData, PixValid, FrameStart, BufferWriteDataDone, BlockConsumed,
    output PixReady, RequestWriteBuffer, BufferWriteData, BufferWriteOffset, FlipBuffer, BlockReady, BlockCount, SchedError
  );
  modport slave (
    output PixData, PixValid, FrameStart, BufferWriteDataDone, BlockConsumed,
    input PixReady, RequestWriteBuffer, BufferWriteData, BufferWriteOffset, FlipBuffer, BlockReady, BlockCount, SchedError
  );
endinterface

// File: rtl/ag32gbd_frame_sched_wdt.sv
// ag32gbd_sched_wdt: Done-wait watchdog; clk_i/rst_ni, run_i counts (low reloads), expire_o on the LIMIT-th run cycle.
module ag32gbd_sched_wdt #(parameter int LIMIT = 15) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  output logic expire_o
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= run_i ? cnt_q + W'(1) : '0;
  end
  assign expire_o = run_i && cnt_q == W'(LIMIT - 1);
endmodule

// File: rtl/ag32gbd_frame_sched.sv
// ag32gbd_frame_sched: pixel byte stream to BufferWrite transactions with double-buffer flip; ports sys_clock, resetn (async low), bus (master); watchdog under AG32GBD_SCHED_WDT_EN.
module ag32gbd_frame_sched import ag32gbd_frame_sched_pkg::*; #(
  parameter int BLOCK_BYTES = BLOCK_BYTES_DEF,
  parameter int OFFSET_W = OFFSET_W_DEF
`ifdef AG32GBD_SCHED_WDT_EN
  , parameter int WDT_CYCLES = 15
`endif
) (
  input logic sys_clock,
  input logic resetn,
  ag32gbd_frame_sched_if.master bus
);
  state_e state_q, state_d;
  logic [7:0] data_q, data_d, count_q, count_d;
  logic [OFFSET_W-1:0] off_q, off_d;
  logic [OFFSET_W:0] off_inc;
  logic req_q, req_d, ready_q, ready_d, flip_q, flip_d, blk_q, blk_d, free_q, free_d, pend_q, pend_d;
  logic consume, free_now, expire;
  assign off_inc = {1'b0, off_q} + (OFFSET_W+1)'(1);
  // a consume pulse frees the reader buffer in time for a flip in the same cycle
  assign consume = bus.BlockConsumed && blk_q;
  assign free_now = free_q || consume;
`ifdef AG32GBD_SCHED_WDT_EN
  logic wdt_exp, err_q;
  ag32gbd_sched_wdt #(.LIMIT(WDT_CYCLES)) u_wdt (
    .clk_i(sys_clock), .rst_ni(resetn), .run_i(state_q == S_WAIT_DONE), .expire_o(wdt_exp)
  );
  assign expire = wdt_exp && !bus.BufferWriteDataDone;
  always_ff @(posedge sys_clock or negedge resetn) begin
    if (!resetn) err_q <= 1'b0;
    else err_q <= err_q || expire;
  end
  assign bus.SchedError = err_q;
`else
  assign expire = 1'b0;
  assign bus.SchedError = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    data_d = data_q;
    off_d = off_q;
    req_d = req_q;
    flip_d = flip_q;
    count_d = count_q;
    pend_d = pend_q;
    blk_d = consume ? 1'b0 : blk_q;
    free_d = free_now;
    case (state_q)
      S_IDLE: begin
        off_d = bus.FrameStart ? '0 : off_q;
        if (bus.PixValid && ready_q) begin
          data_d = bus.PixData;
          req_d = 1'b1;
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        pend_d = pend_q || bus.FrameStart;
        if (bus.BufferWriteDataDone) begin
          req_d = 1'b0;
          pend_d = 1'b0;
          // a restart requested during the write discards the block even if this byte completed it
          off_d = (pend_q || bus.FrameStart) ? '0 : off_inc[OFFSET_W-1:0];
          state_d = (!pend_q && !bus.FrameStart && off_inc == (OFFSET_W+1)'(BLOCK_BYTES)) ? S_FULL : S_GAP;
        end else if (expire) begin
          req_d = 1'b0;
          pend_d = 1'b0;
          off_d = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        off_d = bus.FrameStart ? '0 : off_q;
        state_d = S_IDLE;
      end
      S_FULL: begin
        if (free_now) begin
          flip_d = !flip_q;
          off_d = '0;
          blk_d = 1'b1;
          free_d = 1'b0;
          count_d = count_q + 8'd1;
          state_d = S_GAP;
        end
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = state_d == S_IDLE;
  end
  always_ff @(posedge sys_clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      data_q <= '0;
      off_q <= '0;
      req_q <= 1'b0;
      ready_q <= 1'b0;
      flip_q <= 1'b0;
      blk_q <= 1'b0;
      free_q <= 1'b1;
      pend_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      off_q <= off_d;
      req_q <= req_d;
      ready_q <= ready_d;
      flip_q <= flip_d;
      blk_q <= blk_d;
      free_q <= free_d;
      pend_q <= pend_d;
      count_q <= count_d;
    end
  end
  assign bus.PixReady = ready_q;
  assign bus.RequestWriteBuffer = req_q;
  assign bus.BufferWriteData = data_q;
  assign bus.BufferWriteOffset = off_q;
  assign bus.FlipBuffer = flip_q;
  assign bus.BlockReady = blk_q;
  assign bus.BlockCount = count_q;
endmodule

// File: tb/tb_ag32gbd_frame_sched.sv
// tb_ag32gbd_frame_sched: scoreboard bench with a BRAM ctrl model (Done 3 cycles after request) and a block-level reference model.
module tb_ag32gbd_frame_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  ag32gbd_frame_sched_if ifc();
  ag32gbd_frame_sched dut (.sys_clock(clk), .resetn(rst_n), .bus(ifc));
  int n_checks = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];
  int m_off = 0;
  int m_count = 0;
  bit m_ready = 0;
  bit m_free = 1;
  bit m_pend = 0;
  bit withhold = 0;
  bit arm_consume = 0;
  logic cons_r = 1'b0;
  logic done_r = 1'b0;
  int rcnt = 0;
  assign ifc.BufferWriteDataDone = done_r;
  assign ifc.BlockConsumed = cons_r | (arm_consume & done_r);
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  function automatic void try_flip();
    if (m_pend && m_free) begin
      m_count = (m_count + 1) % 256;
      m_ready = 1;
      m_free = 0;
      m_pend = 0;
    end
  endfunction
  function automatic void m_consume();
    if (m_ready) begin
      m_ready = 0;
      m_free = 1;
      try_flip();
    end
  endfunction
  always @(posedge clk) begin
    #1;
    if (!rst_n || !ifc.RequestWriteBuffer || done_r) begin
      rcnt = 0;
      done_r = 1'b0;
    end else begin
      rcnt++;
      done_r = (rcnt >= 3) && !withhold;
    end
  end
  always @(negedge clk) begin : mon
    logic [15:0] e;
    if (rst_n && ifc.RequestWriteBuffer && ifc.BufferWriteDataDone) begin
      if (exp_q.size() == 0) chk("unexpected_write", ifc.BufferWriteOffset, 32'hFFFF);
      else begin
        e = exp_q.pop_front();
        chk("wr_offset", ifc.BufferWriteOffset, e[15:8]);
        chk("wr_data", ifc.BufferWriteData, e[7:0]);
      end
    end
  end
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(input logic [7:0] d, input bit push);
    int t = 0;
    ifc.PixData = d;
    ifc.PixValid = 1'b1;
    while (ifc.PixReady !== 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("accept_timeout", t < 400, 1);
    if (t < 400) begin
      @(posedge clk);
      #1;
      if (push) exp_q.push_back({m_off[7:0], d});
      m_off++;
      if (m_off == 256) begin
        m_off = 0;
        m_pend = 1;
        try_flip();
      end
    end
    ifc.PixValid = 1'b0;
  endtask
  task automatic send_rand(input int n);
    for (int i = 0; i < n; i++) begin
      send(8'($urandom), 1);
      cyc($urandom_range(0, 2));
    end
  endtask
  task automatic wait_idle();
    int t = 0;
    while (ifc.PixReady !== 1'b1 && t < 400) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("idle_timeout", t < 400, 1);
  endtask
  task automatic fs();
    ifc.FrameStart = 1'b1;
    cyc(1);
    ifc.FrameStart = 1'b0;
    m_off = 0;
  endtask
  task automatic consume();
    cons_r = 1'b1;
    cyc(1);
    cons_r = 1'b0;
    m_consume();
  endtask
  task automatic chk_status(input string nm);
    chk({nm, "_count"}, ifc.BlockCount, m_count);
    chk({nm, "_flip"}, ifc.FlipBuffer, m_count[0]);
    chk({nm, "_blockready"}, ifc.BlockReady, m_ready);
  endtask
  task automatic chk_reset(input string nm);
    chk({nm, "_pixready"}, ifc.PixReady, 0);
    chk({nm, "_req"}, ifc.RequestWriteBuffer, 0);
    chk({nm, "_data"}, ifc.BufferWriteData, 0);
    chk({nm, "_offset"}, ifc.BufferWriteOffset, 0);
    chk({nm, "_flip"}, ifc.FlipBuffer, 0);
    chk({nm, "_blockready"}, ifc.BlockReady, 0);
    chk({nm, "_count"}, ifc.BlockCount, 0);
    chk({nm, "_err"}, ifc.SchedError, 0);
  endtask
  initial begin
    int t;
    ifc.PixData = '0;
    ifc.PixValid = 1'b0;
    ifc.FrameStart = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset("reset");
    cyc(3);
    rst_n = 1'b1;
    cyc(1);
    // full block of 0x00..0xFF with the reader free: flips immediately
    for (int i = 0; i < 256; i++) begin
      send(8'(i), 1);
      cyc($urandom_range(0, 2));
    end
    wait_idle();
    chk_status("blk1");
    // second block with no consume: must stall in FULL
    send_rand(256);
    cyc(20);
    chk("stall_pixready", ifc.PixReady, !m_pend);
    chk_status("stall");
    consume();
    chk_status("flip2");
    wait_idle();
    // FrameStart in IDLE and during WAIT_DONE
    consume();
    chk_status("freed");
    send_rand(100);
    wait_idle();
    fs();
    send_rand(5);
    wait_idle();
    send(8'($urandom), 1);
    fs();
    send_rand(3);
    wait_idle();
    chk_status("restart");
    // consume coincident with Done of the last byte
    fs();
    send_rand(256);
    send_rand(255);
    wait_idle();
    chk_status("pre_last");
    arm_consume = 1;
    m_consume();
    send(8'($urandom), 1);
    cyc(10);
    arm_consume = 0;
    chk_status("coincident");
    wait_idle();
    // Done withheld
    withhold = 1;
`ifdef AG32GBD_SCHED_WDT_EN
    send(8'($urandom), 0);
    cyc(10);
    chk("wdt_req_held", ifc.RequestWriteBuffer, 1);
    cyc(10);
    chk("wdt_req_dropped", ifc.RequestWriteBuffer, 0);
    chk("wdt_err", ifc.SchedError, 1);
    chk("wdt_offset", ifc.BufferWriteOffset, 0);
    m_off = 0;
    withhold = 0;
`else
    send(8'($urandom), 1);
    cyc(100);
    chk("hold_req", ifc.RequestWriteBuffer, 1);
    chk("hold_err", ifc.SchedError, 0);
    withhold = 0;
`endif
    send_rand(2);
    wait_idle();
    // asynchronous reset during WAIT_DONE
    withhold = 1;
    send(8'($urandom), 0);
    cyc(2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset("midreset");
    m_off = 0;
    m_count = 0;
    m_ready = 0;
    m_free = 1;
    m_pend = 0;
    withhold = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    send_rand(3);
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      cyc(1);
      t++;
    end
    chk("queue_drained", exp_q.size(), 0);
    chk_status("final");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
